// File: rtl/memory_game_ctrl_if.sv
//------------------------------------------------------------------------------
// memory_game_ctrl_if
//
// Purpose: groups the game controller's data and handshake signals so that the
// controller and its neighbours (random_digit source, keypad debouncer,
// 7-segment decoder) connect through one bundle.
//
// Signals:
//   rnd        4  random value from random_digit, meaningful only when 0..9
//   start      1  one-cycle pulse, starts or restarts a game
//   key_valid  1  one-cycle pulse, key_digit carries a pressed key
//   key_digit  4  digit pressed by the player
//   seg_digit  4  digit for the 7-segment decoder
//   seg_blank  1  1 = display dark
//   level      4  current sequence length (0 when idle)
//   busy       1  1 while capturing or playing back (keys ignored)
//   win        1  held high after a complete winning game
//   lose       1  held high after a wrong key (or timeout)
//
// Modports:
//   master  environment side: drives rnd/start/keys, observes the display
//   slave   controller side: the memory_game_ctrl module
//------------------------------------------------------------------------------
interface memory_game_ctrl_if;
  logic [3:0] rnd;
  logic       start;
  logic       key_valid;
  logic [3:0] key_digit;
  logic [3:0] seg_digit;
  logic       seg_blank;
  logic [3:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  modport master (
    output rnd, start, key_valid, key_digit,
    input  seg_digit, seg_blank, level, busy, win, lose
  );

  modport slave (
    input  rnd, start, key_valid, key_digit,
    output seg_digit, seg_blank, level, busy, win, lose
  );
endinterface

// File: rtl/memory_game_ctrl.sv
//------------------------------------------------------------------------------
// memory_game_ctrl
//
// Purpose: Simon-style digit-memory game controller. Each round it captures
// one random decimal digit into a sequence buffer, plays the whole sequence
// back on the 7-segment display, then checks the player's keys against it.
// Matching a full sequence of MAX_LEN digits wins; any wrong key loses.
//
// Ports:
//   clk    in   system clock, all logic on the rising edge
//   reset  in   asynchronous active-low reset (0 = reset)
//   bus    slave modport of memory_game_ctrl_if:
//            rnd, start, key_valid, key_digit        (inputs)
//            seg_digit, seg_blank, level, busy, win, lose (registered outputs)
//
// Parameters:
//   MAX_LEN        longest sequence (1..15); matching it completely wins
//   SHOW_CYCLES    cycles each digit is lit during playback
//   GAP_CYCLES     blank cycles after each playback digit
//   INPUT_TIMEOUT  cycles allowed per key press (timeout build only)
//
// Build option:
//   MEMORY_GAME_TIMEOUT_EN  when defined, INPUT loses after INPUT_TIMEOUT
//                           cycles without a key; when undefined INPUT waits
//                           indefinitely and no timeout logic exists.
//------------------------------------------------------------------------------
module memory_game_ctrl #(
  parameter int unsigned MAX_LEN       = 8,
  parameter int unsigned SHOW_CYCLES   = 25000000,
  parameter int unsigned GAP_CYCLES    = 5000000,
  parameter int unsigned INPUT_TIMEOUT = 250000000
) (
  input  logic               clk,
  input  logic               reset,
  memory_game_ctrl_if.slave  bus
);

  // Larger of two elaboration-time values, used to size the shared counter.
  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

`ifdef MEMORY_GAME_TIMEOUT_EN
  localparam int unsigned CNT_MAX = max_of(max_of(SHOW_CYCLES, GAP_CYCLES), INPUT_TIMEOUT);
`else
  localparam int unsigned CNT_MAX = max_of(SHOW_CYCLES, GAP_CYCLES);
`endif
  // The counter only ever holds 0..CNT_MAX-1.
  localparam int unsigned CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef MEMORY_GAME_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INPUT_TIMEOUT - 1);
`endif
  localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

  // Reject configurations the 4-bit level/digit datapath cannot represent.
  if ((MAX_LEN < 1) || (MAX_LEN > 15) || (SHOW_CYCLES < 1) ||
      (GAP_CYCLES < 1) || (INPUT_TIMEOUT < 1)) begin : g_param_check
    $error("memory_game_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAPTURE  = 3'd1,
    ST_SHOW_ON  = 3'd2,
    ST_SHOW_OFF = 3'd3,
    ST_INPUT    = 3'd4,
    ST_WIN      = 3'd5,
    ST_LOSE     = 3'd6
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       level_r, level_s;
  logic [3:0]       idx_r, idx_s;
  logic [3:0]       idx_inc_s;
  logic [3:0]       last_idx_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       seg_digit_r, seg_digit_s;
  logic             seg_blank_r, seg_blank_s;
  logic             busy_r, busy_s;
  logic             win_r, win_s;
  logic             lose_r, lose_s;
  logic             buf_we_s;

  // Sized to the full 4-bit index range so every level/idx value addresses
  // a real entry; only the first MAX_LEN entries are ever written.
  logic [3:0]       seq_buf_r [16];

  assign bus.seg_digit = seg_digit_r;
  assign bus.seg_blank = seg_blank_r;
  assign bus.level     = level_r;
  assign bus.busy      = busy_r;
  assign bus.win       = win_r;
  assign bus.lose      = lose_r;

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      level_r     <= 4'd0;
      idx_r       <= 4'd0;
      cnt_r       <= {CNT_W{1'b0}};
      seg_digit_r <= 4'd0;
      seg_blank_r <= 1'b1;
      busy_r      <= 1'b0;
      win_r       <= 1'b0;
      lose_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      level_r     <= level_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      seg_digit_r <= seg_digit_s;
      seg_blank_r <= seg_blank_s;
      busy_r      <= busy_s;
      win_r       <= win_s;
      lose_r      <= lose_s;
    end
  end

  // Sequence buffer: one valid random digit appended per CAPTURE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        seq_buf_r[i] <= 4'd0;
      end
    end else if (buf_we_s) begin
      seq_buf_r[level_r] <= bus.rnd;
    end
  end

  // Next-state and next-output logic; outputs follow the state being entered.
  always_comb begin
    state_s     = state_r;
    level_s     = level_r;
    idx_s       = idx_r;
    cnt_s       = {CNT_W{1'b0}};   // any state change restarts the counter
    seg_digit_s = seg_digit_r;
    seg_blank_s = seg_blank_r;
    buf_we_s    = 1'b0;
    idx_inc_s   = idx_r + 4'd1;
    last_idx_s  = level_r - 4'd1;

    case (state_r)
      ST_IDLE: begin
        seg_blank_s = 1'b1;
        if (bus.start) begin
          state_s = ST_CAPTURE;
          level_s = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CAPTURE: begin
        if (bus.rnd <= 4'd9) begin
          buf_we_s    = 1'b1;
          level_s     = level_r + 4'd1;
          idx_s       = 4'd0;
          state_s     = ST_SHOW_ON;
          // buf[0] is being written this very edge in the first round.
          seg_digit_s = (level_r == 4'd0) ? bus.rnd : seq_buf_r[4'd0];
          seg_blank_s = 1'b0;
        end else begin
          seg_blank_s = 1'b1;
          state_s     = ST_CAPTURE;
        end
      end

      ST_SHOW_ON: begin
        if (cnt_r == SHOW_LAST) begin
          state_s     = ST_SHOW_OFF;
          seg_blank_s = 1'b1;
        end else begin
          cnt_s       = cnt_r + CNT_W'(1);
          seg_blank_s = 1'b0;
        end
      end

      ST_SHOW_OFF: begin
        seg_blank_s = 1'b1;
        if (cnt_r == GAP_LAST) begin
          if (idx_r == last_idx_s) begin
            state_s = ST_INPUT;
            idx_s   = 4'd0;
          end else begin
            state_s     = ST_SHOW_ON;
            idx_s       = idx_inc_s;
            seg_digit_s = seq_buf_r[idx_inc_s];
            seg_blank_s = 1'b0;
          end
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      ST_INPUT: begin
        if (bus.key_valid) begin
          // Echo the key; a state change below overrides the echo.
          seg_digit_s = bus.key_digit;
          seg_blank_s = 1'b0;
          // Buffer holds only 0..9, so keys above 9 never match.
          if (bus.key_digit == seq_buf_r[idx_r]) begin
            if (idx_r == last_idx_s) begin
              seg_blank_s = 1'b1;
              if (level_r == MAX_LEN_L) begin
                state_s = ST_WIN;
              end else begin
                state_s = ST_CAPTURE;
              end
            end else begin
              idx_s = idx_inc_s;
            end
          end else begin
            state_s     = ST_LOSE;
            seg_digit_s = last_idx_s;
            seg_blank_s = 1'b0;
          end
        end else begin
`ifdef MEMORY_GAME_TIMEOUT_EN
          if (cnt_r == TIMEOUT_LAST) begin
            state_s     = ST_LOSE;
            seg_digit_s = last_idx_s;
            seg_blank_s = 1'b0;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
`else
          state_s = ST_INPUT;
`endif
        end
      end

      ST_WIN: begin
        seg_blank_s = 1'b1;
        if (bus.start) begin
          state_s = ST_CAPTURE;
          level_s = 4'd0;
        end else begin
          state_s = ST_WIN;
        end
      end

      ST_LOSE: begin
        if (bus.start) begin
          state_s     = ST_CAPTURE;
          level_s     = 4'd0;
          seg_blank_s = 1'b1;
        end else begin
          // Score shown while lost: number of rounds fully completed.
          seg_digit_s = last_idx_s;
          seg_blank_s = 1'b0;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        level_s     = 4'd0;
        idx_s       = 4'd0;
        seg_digit_s = 4'd0;
        seg_blank_s = 1'b1;
      end
    endcase

    busy_s = (state_s == ST_CAPTURE) || (state_s == ST_SHOW_ON) ||
             (state_s == ST_SHOW_OFF);
    win_s  = (state_s == ST_WIN);
    lose_s = (state_s == ST_LOSE);
  end

endmodule

// File: tb/tb_memory_game_ctrl.sv
//------------------------------------------------------------------------------
// tb_memory_game_ctrl
//
// Purpose: self-checking bench for memory_game_ctrl. A reference model holds
// the game as a queue of captured digits and derives the expected display,
// level and win/lose flags from the game rules. Directed games cover the
// named scenarios; further games use random digits, invalid rnd stalls,
// random wrong keys and random ignored start/key activity.
//------------------------------------------------------------------------------
module tb_memory_game_ctrl;

  localparam int MAX_LEN = 3;
  localparam int SHOW    = 4;
  localparam int GAP     = 2;
  localparam int TOUT    = 20;

  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  logic [3:0] seq [$];       // model: digits captured so far this game
  int g_dig [3];
  int g_bad [3];
  int g_fail_r;
  int g_fail_p;
  int g_fail_k;              // -1: pick a random wrong key

  memory_game_ctrl_if bus ();

  memory_game_ctrl #(
    .MAX_LEN       (MAX_LEN),
    .SHOW_CYCLES   (SHOW),
    .GAP_CYCLES    (GAP),
    .INPUT_TIMEOUT (TOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.key_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  task automatic junk();
    bus.key_valid = 1'($urandom_range(0, 1));
    bus.key_digit = 4'($urandom_range(0, 15));
    bus.start     = 1'($urandom_range(0, 1));
  endtask

  // From just after SHOW_ON entry: every digit lit SHOW cycles, GAP blank.
  task automatic play_check();
    for (int i = 0; i < seq.size(); i++) begin
      for (int c = 0; c < SHOW; c++) begin
        chk_eq("show_blank", 32'(bus.seg_blank), 32'd0);
        chk_eq("show_digit", 32'(bus.seg_digit), 32'(seq[i]));
        chk_eq("show_busy", 32'(bus.busy), 32'd1);
        junk();
        tick();
      end
      for (int g = 0; g < GAP; g++) begin
        chk_eq("gap_blank", 32'(bus.seg_blank), 32'd1);
        chk_eq("gap_busy", 32'(bus.busy), 32'd1);
        junk();
        tick();
      end
    end
    quiet();
    chk_eq("input_busy", 32'(bus.busy), 32'd0);
    chk_eq("input_blank", 32'(bus.seg_blank), 32'd1);
    chk_eq("input_level", 32'(bus.level), 32'(seq.size()));
    chk_eq("input_win", 32'(bus.win), 32'd0);
    chk_eq("input_lose", 32'(bus.lose), 32'd0);
  endtask

  task automatic capture_round(input logic [3:0] d, input int nbad, input bit newg);
    if (newg) begin
      bus.start = 1'b1;
      bus.rnd   = 4'($urandom_range(0, 15));
      tick();
      quiet();
      seq.delete();
      chk_eq("start_busy", 32'(bus.busy), 32'd1);
      chk_eq("start_blank", 32'(bus.seg_blank), 32'd1);
      chk_eq("start_level", 32'(bus.level), 32'd0);
      chk_eq("start_win", 32'(bus.win), 32'd0);
      chk_eq("start_lose", 32'(bus.lose), 32'd0);
    end
    for (int b = 0; b < nbad; b++) begin
      bus.rnd = 4'($urandom_range(10, 15));
      junk();
      tick();
      quiet();
      chk_eq("stall_busy", 32'(bus.busy), 32'd1);
      chk_eq("stall_blank", 32'(bus.seg_blank), 32'd1);
      chk_eq("stall_level", 32'(bus.level), 32'(seq.size()));
    end
    bus.rnd = d;
    tick();
    seq.push_back(d);
    play_check();
  endtask

  // Model decides the outcome of one key from the queue and position.
  task automatic press(input logic [3:0] k, input int p, output bit ended);
    int n;
    bus.key_valid = 1'b1;
    bus.key_digit = k;
    bus.start     = 1'($urandom_range(0, 1));
    tick();
    quiet();
    ended = 1'b1;
    if (k != seq[p]) begin
      chk_eq("lose_flag", 32'(bus.lose), 32'd1);
      chk_eq("lose_score", 32'(bus.seg_digit), 32'(seq.size() - 1));
      chk_eq("lose_blank", 32'(bus.seg_blank), 32'd0);
      chk_eq("lose_busy", 32'(bus.busy), 32'd0);
      repeat (2) begin
        bus.key_valid = 1'b1;
        bus.key_digit = 4'($urandom_range(0, 15));
        tick();
        quiet();
        chk_eq("lose_hold_score", 32'(bus.seg_digit), 32'(seq.size() - 1));
        chk_eq("lose_hold_flag", 32'(bus.lose), 32'd1);
      end
    end else if (p == seq.size() - 1) begin
      if (seq.size() == MAX_LEN) begin
        chk_eq("win_flag", 32'(bus.win), 32'd1);
        chk_eq("win_blank", 32'(bus.seg_blank), 32'd1);
        chk_eq("win_level", 32'(bus.level), 32'(MAX_LEN));
        chk_eq("win_busy", 32'(bus.busy), 32'd0);
        repeat (2) begin
          bus.key_valid = 1'b1;
          bus.key_digit = 4'($urandom_range(0, 15));
          tick();
          quiet();
          chk_eq("win_hold_blank", 32'(bus.seg_blank), 32'd1);
          chk_eq("win_hold_flag", 32'(bus.win), 32'd1);
        end
      end else begin
        chk_eq("next_busy", 32'(bus.busy), 32'd1);
        chk_eq("next_blank", 32'(bus.seg_blank), 32'd1);
        chk_eq("next_level", 32'(bus.level), 32'(seq.size()));
        chk_eq("next_lose", 32'(bus.lose), 32'd0);
        ended = 1'b0;
      end
    end else begin
      chk_eq("echo_blank", 32'(bus.seg_blank), 32'd0);
      chk_eq("echo_digit", 32'(bus.seg_digit), 32'(k));
      chk_eq("echo_busy", 32'(bus.busy), 32'd0);
      chk_eq("echo_lose", 32'(bus.lose), 32'd0);
      n = $urandom_range(0, 3);
      repeat (n) begin
        tick();
        chk_eq("echo_hold", 32'({bus.seg_blank, bus.seg_digit}), 32'({1'b0, k}));
      end
      ended = 1'b0;
    end
  endtask

  task automatic run_game();
    bit ended;
    logic [3:0] k;
    ended = 1'b0;
    for (int r = 0; r < MAX_LEN && !ended; r++) begin
      capture_round(4'(g_dig[r]), g_bad[r], r == 0);
      for (int p = 0; p <= r && !ended; p++) begin
        k = seq[p];
        if (r == g_fail_r && p == g_fail_p) begin
          if (g_fail_k >= 0) k = 4'(g_fail_k);
          else k = seq[p] + 4'($urandom_range(1, 15));
        end
        press(k, p, ended);
      end
    end
  endtask

  initial begin
    bit ended;
    reset         = 1'b0;
    bus.start     = 1'b1;
    bus.rnd       = 4'd0;
    bus.key_valid = 1'b0;
    bus.key_digit = 4'd0;

    // Reset held with start asserted.
    repeat (3) tick();
    chk_eq("rst_blank", 32'(bus.seg_blank), 32'd1);
    chk_eq("rst_digit", 32'(bus.seg_digit), 32'd0);
    chk_eq("rst_level", 32'(bus.level), 32'd0);
    chk_eq("rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("rst_win", 32'(bus.win), 32'd0);
    chk_eq("rst_lose", 32'(bus.lose), 32'd0);
    reset     = 1'b1;
    bus.start = 1'b0;
    repeat (3) tick();
    chk_eq("idle_busy", 32'(bus.busy), 32'd0);
    chk_eq("idle_blank", 32'(bus.seg_blank), 32'd1);

    // Full win 3,8,1.
    g_dig = '{3, 8, 1}; g_bad = '{0, 0, 0}; g_fail_r = -1; g_fail_p = 0; g_fail_k = -1;
    run_game();
    // Lose in round 2 with keys 3 then 9.
    g_dig = '{3, 8, 0}; g_bad = '{0, 0, 0}; g_fail_r = 1; g_fail_p = 1; g_fail_k = 9;
    run_game();
    // Invalid rnd stall before 5, then a key above 9.
    g_dig = '{5, 0, 0}; g_bad = '{3, 0, 0}; g_fail_r = 0; g_fail_p = 0; g_fail_k = 12;
    run_game();
    // Playback of 7, then a random wrong key in round 2.
    g_dig = '{7, 2, 4}; g_bad = '{0, 1, 2}; g_fail_r = 1; g_fail_p = 0; g_fail_k = -1;
    run_game();

    repeat (12) begin
      for (int i = 0; i < 3; i++) begin
        g_dig[i] = $urandom_range(0, 9);
        g_bad[i] = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 1) == 1) begin
        g_fail_r = $urandom_range(0, MAX_LEN - 1);
        g_fail_p = $urandom_range(0, g_fail_r);
      end else begin
        g_fail_r = -1;
        g_fail_p = 0;
      end
      g_fail_k = -1;
      run_game();
    end

    // INPUT with no key.
    capture_round(4'($urandom_range(0, 9)), 0, 1'b1);
`ifdef MEMORY_GAME_TIMEOUT_EN
    repeat (TOUT - 1) tick();
    chk_eq("to_not_yet", 32'(bus.lose), 32'd0);
    tick();
    chk_eq("to_lose", 32'(bus.lose), 32'd1);
    chk_eq("to_score", 32'(bus.seg_digit), 32'd0);
`else
    repeat (2 * TOUT) tick();
    chk_eq("wait_lose", 32'(bus.lose), 32'd0);
    chk_eq("wait_busy", 32'(bus.busy), 32'd0);
    chk_eq("wait_blank", 32'(bus.seg_blank), 32'd1);
    press(seq[0] + 4'd1, 0, ended);
`endif

    // Reset in the middle of playback.
    bus.start = 1'b1;
    bus.rnd   = 4'd6;
    tick();
    quiet();
    tick();
    chk_eq("mid_lit", 32'(bus.seg_blank), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("mid_rst_blank", 32'(bus.seg_blank), 32'd1);
    chk_eq("mid_rst_level", 32'(bus.level), 32'd0);
    chk_eq("mid_rst_lose", 32'(bus.lose), 32'd0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    chk_eq("post_rst_busy", 32'(bus.busy), 32'd0);
    chk_eq("post_rst_level", 32'(bus.level), 32'd0);

    // Game from IDLE after the reset.
    g_dig = '{9, 0, 4}; g_bad = '{1, 0, 0}; g_fail_r = -1; g_fail_p = 0; g_fail_k = -1;
    run_game();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
- Consumer of the `random_digit` output stream, for a Simon-style digit-memory game on the 7-segment display.
- Captures one random decimal digit per round into a sequence buffer and plays the sequence back on the display.
- Accepts the player's key digits and compares them against the buffer. Reports win or lose.
- Sits between `random_digit` (rnd source), the keypad debouncer (key pulses) and the 7-segment decoder (`seg_digit`/`seg_blank`).

Parameters:
- MAX_LEN, 8: longest sequence; reaching it and matching it completely is a win (1..15).
- SHOW_CYCLES, 25000000: clock cycles each digit is lit during playback.
- GAP_CYCLES, 5000000: clock cycles blank between playback digits.
- INPUT_TIMEOUT, 250000000: cycles allowed per key press; used only with TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- rnd  in  4  random value from random_digit; valid only when 0..9
- start  in  1  one-cycle pulse; starts or restarts a game
- key_valid  in  1  one-cycle pulse; key_digit is valid
- key_digit  in  4  digit pressed by player
- seg_digit  out  4  digit for the 7-segment decoder
- seg_blank  out  1  1 = display dark
- level  out  4  current sequence length (0 when idle)
- busy  out  1  1 during CAPTURE/SHOW_ON/SHOW_OFF (keys ignored)
- win  out  1  held high in WIN state
- lose  out  1  held high in LOSE state

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE, seg_digit=0, seg_blank=1, level=0, busy=0, win=0, lose=0, buffer contents don't-care, counters=0.
- All outputs are registered.
- States: IDLE, CAPTURE, SHOW_ON, SHOW_OFF, INPUT, WIN, LOSE.
- IDLE: display blank.
  - start=1 -> CAPTURE next cycle, level=0.
- CAPTURE: if rnd<=9, write rnd to buf[level], level<=level+1, idx<=0, then -> SHOW_ON.
  - If rnd>9, stay in CAPTURE and resample next cycle.
  - busy=1.
- SHOW_ON: seg_digit=buf[idx], seg_blank=0 for exactly SHOW_CYCLES cycles, then -> SHOW_OFF.
- SHOW_OFF: seg_blank=1 for exactly GAP_CYCLES cycles.
  - If idx==level-1 -> INPUT with idx<=0.
  - Otherwise idx<=idx+1 -> SHOW_ON.
- INPUT: busy=0; display blank until the first key.
  - On key_valid: seg_digit<=key_digit, seg_blank<=0 (echo).
  - If key_digit==buf[idx] and idx<level-1: idx<=idx+1.
  - If match and idx==level-1:
    - level==MAX_LEN -> WIN.
    - Otherwise -> CAPTURE.
  - If mismatch (including key_digit>9) -> LOSE.
  - Echo persists until the next key or a state change.
- WIN: win=1, seg_blank=1. LOSE: lose=1, seg_digit=level-1 (score), seg_blank=0.
  - Both hold until start=1 -> CAPTURE with level=0; win/lose clear on that edge.
- start while busy or in INPUT: ignored.
- key_valid outside INPUT: ignored, no echo.
- key_valid and start in the same cycle in INPUT: key processed, start ignored.
- Counters are wide enough for the largest parameter ($clog2) and reset to 0 on every state entry.
- Reset asserted mid-game: immediate return to IDLE values. No state survives reset.
- Latency: start pulse -> first lit digit = 2 cycles when rnd<=9 (IDLE->CAPTURE->SHOW_ON).
- After the last matching key, a new digit is shown at least 2 cycles later.

Optional Feature:
- Macro: MEMORY_GAME_TIMEOUT_EN.
- Defined: in INPUT, a cycle counter runs from state entry and restarts on each key_valid. Reaching INPUT_TIMEOUT with no key -> LOSE.
- Undefined: no counter logic is synthesised. INPUT waits indefinitely. INPUT_TIMEOUT is unused.

Test Plan:
- Bench parameters for all scenarios: MAX_LEN=3, SHOW_CYCLES=4, GAP_CYCLES=2, INPUT_TIMEOUT=20.
- Reset: hold reset=0 for 3 cycles with start=1 -> seg_blank=1, level=0, win=0, lose=0, state IDLE. Release reset -> still IDLE until a new start pulse.
- Playback: drive rnd=7, pulse start -> seg_digit=7, seg_blank=0 for exactly 4 cycles, blank for 2, then busy=0, level=1.
- Invalid rnd: rnd=12 for 3 cycles then 5 in CAPTURE -> buf[0]=5, first lit digit is 5, level=1.
- Full win: rnd 3,8,1 captured over three rounds, correct keys each round -> win=1 after the 3rd key of round 3, level=3. A start pulse then clears win.
- Lose: round 2 sequence 3,8, keys 3 then 9 -> lose=1, seg_digit=1, seg_blank=0. key_valid while busy produces no echo and no state change.
- Timeout (macro defined): INPUT with no key for 20 cycles -> lose=1. With the macro undefined, the same stimulus stays in INPUT, lose=0.
